// File: rtl/tx_buf_frame_reader.sv
// TX frame buffer reader: streams committed frames to the MAC and releases space.
// Optional TX_FRAME_STATS_EN adds frame and descriptor-error counters.
module tx_buf_frame_reader #(
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int RD_LATENCY      = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  commited_wr_addr,
  output logic [9:0]  rd_addr,
  input  logic [63:0] rd_data,
  output logic [63:0] mac_data,
  output logic [7:0]  mac_keep,
  output logic        mac_valid,
  output logic        mac_last,
  input  logic        mac_ready,
  output logic [9:0]  commited_rd_addr,
  output logic        desc_err
`ifdef TX_FRAME_STATS_EN
  ,
  output logic [31:0] tx_frame_cnt,
  output logic [15:0] tx_err_cnt
`endif
);

  typedef enum logic [1:0] {
    s_idle,
    s_desc_wait,
    s_data,
    s_commit
  } state_t;

  localparam logic [3:0] LAT = 4'(RD_LATENCY);

  state_t state;
  logic [9:0] base;
  logic [9:0] rd_ptr;
  logic [7:0] rem;
  logic [7:0] keep_last;
  logic [3:0] wcnt;
  logic [RD_LATENCY:0] vld;
  logic [RD_LATENCY:0] lastp;
  logic [2:0] infl;
  logic [2:0] cnt;
  logic [1:0] wp;
  logic [1:0] rp;

  logic [63:0] f_data [4];
  logic [7:0]  f_keep [4];
  logic [3:0]  f_last;

  logic [15:0] len;
  logic        len_bad;
  logic [7:0]  n_words;
  logic [7:0]  kmask;
  logic [3:0]  occ;
  logic        pop;
  logic        push;
  logic        push_last;
  logic        issue;

  assign len     = rd_data[15:0];
  assign len_bad = (len == 16'd0) || (len > 16'(MAX_FRAME_BYTES));
  assign n_words = len[10:3] + {7'd0, |len[2:0]};
  assign kmask   = (len[2:0] == 3'd0) ? 8'hFF
                 : 8'hFF >> (4'd8 - {1'b0, len[2:0]});

  assign mac_valid = (cnt != 3'd0);
  assign mac_data  = mac_valid ? f_data[rp] : 64'd0;
  assign mac_keep  = mac_valid ? f_keep[rp] : 8'd0;
  assign mac_last  = mac_valid & f_last[rp];

  assign pop       = mac_valid & mac_ready;
  assign push      = vld[RD_LATENCY];
  assign push_last = lastp[RD_LATENCY];
  // A beat leaving this cycle frees its slot for a new read.
  assign occ   = {1'b0, cnt} + {1'b0, infl};
  assign issue = (state == s_data) && (rem != 8'd0)
              && ((occ - {3'd0, pop}) < 4'd4);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= s_idle;
      rd_addr          <= 10'd0;
      commited_rd_addr <= 10'd0;
      desc_err         <= 1'b0;
      base             <= 10'd0;
      rd_ptr           <= 10'd0;
      rem              <= 8'd0;
      keep_last        <= 8'd0;
      wcnt             <= 4'd0;
      vld              <= '0;
      lastp            <= '0;
      infl             <= 3'd0;
    end else begin
      desc_err <= 1'b0;
      vld      <= {vld[RD_LATENCY-1:0], issue};
      lastp    <= {lastp[RD_LATENCY-1:0], issue && (rem == 8'd1)};
      infl     <= infl + {2'd0, issue} - {2'd0, push};
      if (issue) begin
        rd_addr <= rd_ptr;
        rd_ptr  <= rd_ptr + 10'd1;
        rem     <= rem - 8'd1;
      end
      unique case (state)
        s_idle: begin
          if (commited_wr_addr != commited_rd_addr) begin
            rd_addr <= commited_rd_addr;
            base    <= commited_rd_addr;
            wcnt    <= 4'd0;
            state   <= s_desc_wait;
          end
        end
        s_desc_wait: begin
          if (wcnt == LAT) begin
            if (len_bad) begin
              desc_err         <= 1'b1;
              commited_rd_addr <= base + 10'd1;
              state            <= s_idle;
            end else begin
              rem       <= n_words;
              keep_last <= kmask;
              rd_ptr    <= base + 10'd1;
              state     <= s_data;
            end
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        s_data: begin
          if (pop && mac_last) state <= s_commit;
        end
        s_commit: begin
          commited_rd_addr <= rd_ptr;
          state            <= s_idle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 3'd0;
      wp  <= 2'd0;
      rp  <= 2'd0;
    end else begin
      if (push) wp <= wp + 2'd1;
      if (pop)  rp <= rp + 2'd1;
      cnt <= cnt + {2'd0, push} - {2'd0, pop};
    end
  end

  // Storage needs no reset; outputs are gated by mac_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      f_data[wp] <= rd_data;
      f_keep[wp] <= push_last ? keep_last : 8'hFF;
      f_last[wp] <= push_last;
    end
  end

`ifdef TX_FRAME_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_frame_cnt <= 32'd0;
      tx_err_cnt   <= 16'd0;
    end else begin
      if (state == s_commit) tx_frame_cnt <= tx_frame_cnt + 32'd1;
      if (desc_err)          tx_err_cnt   <= tx_err_cnt + 16'd1;
    end
  end
`endif

endmodule
